fx2_bridge: RTL

- Upstream neighbour of control_top; converts the FX2 synchronous slave-FIFO byte stream into fx bus transactions.
- Host command packets arrive on EP2 OUT and are decoded into fx_wr / fx_rd cycles on the configuration-register bus.
- Read data returns to the host on EP6 IN and is terminated with PKTEND.
- usb_ifclk is externally tied to clk_sys; no clock-domain crossing inside this block.

---
 rtl/fx2_bridge.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fx2_bridge.sv
// FX2 slave-FIFO command stream to fx configuration-bus bridge.
// Define FX2_BRIDGE_ACK_EN to answer every completed write with an 0xA5 packet.
module fx2_bridge #(
   parameter int ADDR_W  = 22,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic [7:0]        usb_fd_i,
   output logic [7:0]        usb_fd_o,
   output logic              usb_fd_oe,
   input  logic              usb_ef_n,
   input  logic              usb_ff_n,
   output logic [1:0]        usb_fifoadr,
   output logic              usb_sloe_n,
   output logic              usb_slrd_n,
   output logic              usb_slwr_n,
   output logic              usb_pktend_n,
   output logic [ADDR_W-1:0] fx_waddr,
   output logic              fx_wr,
   output logic [7:0]        fx_data,
   output logic [ADDR_W-1:0] fx_raddr,
   output logic              fx_rd,
   input  logic [7:0]        fx_q
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADR2, S_ADR1, S_ADR0, S_LEN, S_WDATA,
      S_RREQ, S_RCAP, S_RPUSH, S_PKTEND
`ifdef FX2_BRIDGE_ACK_EN
      , S_ACK
`endif
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_nx;
   logic [13:0]       hi_q;
   logic [21:0]       adr_in;
   logic              wr_q;
   logic [8:0]        cnt_q;
   logic [TW-1:0]     tmo_q;
   logic [7:0]        fd_o_q;
   logic              fd_oe_q;
   logic [1:0]        fifoadr_q;
   logic              sloe_n_q;
   logic              slrd_n_q;
   logic              slwr_n_q;
   logic              pktend_n_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [ADDR_W-1:0] raddr_q;
   logic [7:0]        wdata_q;
   logic              fx_wr_q;
   logic              fx_rd_q;

   logic out_st, in_st, got, put, fetch, stall, expire;

   assign out_st = state_q inside {S_CMD, S_ADR2, S_ADR1, S_ADR0,
                                   S_LEN, S_WDATA};
`ifdef FX2_BRIDGE_ACK_EN
   assign in_st = (state_q == S_RPUSH) || (state_q == S_ACK);
`else
   assign in_st = (state_q == S_RPUSH);
`endif
   assign got     = out_st && !slrd_n_q;
   assign put     = in_st && !slwr_n_q;
   assign fetch   = out_st && slrd_n_q && usb_ef_n &&
                    !(state_q == S_WDATA && cnt_q == 9'd0);
   assign stall   = (out_st && slrd_n_q && !usb_ef_n) ||
                    (in_st && slwr_n_q && !usb_ff_n);
   assign expire  = stall && (tmo_q == TW'(TIMEOUT - 1));
   assign addr_nx = addr_q + ADDR_W'(1);
   assign adr_in  = {hi_q, usb_fd_i};

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         hi_q       <= '0;
         wr_q       <= 1'b0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         fd_o_q     <= '0;
         fd_oe_q    <= 1'b0;
         fifoadr_q  <= 2'b00;
         sloe_n_q   <= 1'b1;
         slrd_n_q   <= 1'b1;
         slwr_n_q   <= 1'b1;
         pktend_n_q <= 1'b1;
         waddr_q    <= '0;
         raddr_q    <= '0;
         wdata_q    <= '0;
         fx_wr_q    <= 1'b0;
         fx_rd_q    <= 1'b0;
      end else begin
         fx_wr_q    <= 1'b0;
         fx_rd_q    <= 1'b0;
         pktend_n_q <= 1'b1;
         if (got) slrd_n_q <= 1'b1;
         if (fetch) slrd_n_q <= 1'b0;
         if (put) slwr_n_q <= 1'b1;
         if (in_st && slwr_n_q && usb_ff_n) slwr_n_q <= 1'b0;
         if (state_q == S_IDLE || got || put) tmo_q <= '0;
         else if (stall) tmo_q <= tmo_q + TW'(1);
         // abort drops the partial command silently
         if (expire) begin
            state_q  <= S_IDLE;
            sloe_n_q <= 1'b1;
            fd_oe_q  <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  fifoadr_q <= 2'b00;
                  if (usb_ef_n) begin
                     state_q  <= S_CMD;
                     sloe_n_q <= 1'b0;
                  end
               end
               S_CMD: if (got) begin
                  if (usb_fd_i == 8'h01 || usb_fd_i == 8'h02) begin
                     wr_q    <= (usb_fd_i == 8'h01);
                     state_q <= S_ADR2;
                  end else begin
                     state_q  <= S_IDLE;
                     sloe_n_q <= 1'b1;
                  end
               end
               S_ADR2: if (got) begin
                  hi_q[13:8] <= usb_fd_i[5:0];
                  state_q    <= S_ADR1;
               end
               S_ADR1: if (got) begin
                  hi_q[7:0] <= usb_fd_i;
                  state_q   <= S_ADR0;
               end
               S_ADR0: if (got) begin
                  addr_q  <= ADDR_W'(adr_in);
                  state_q <= S_LEN;
               end
               S_LEN: if (got) begin
                  cnt_q <= (usb_fd_i == 8'd0) ? 9'd256 : {1'b0, usb_fd_i};
                  if (wr_q) begin
                     state_q <= S_WDATA;
                  end else begin
                     state_q  <= S_RREQ;
                     sloe_n_q <= 1'b1;
                     fx_rd_q  <= 1'b1;
                     raddr_q  <= addr_q;
                  end
               end
               S_WDATA: begin
                  if (cnt_q == 9'd0) begin
                     sloe_n_q <= 1'b1;
`ifdef FX2_BRIDGE_ACK_EN
                     state_q   <= S_ACK;
                     fifoadr_q <= 2'b10;
                     fd_oe_q   <= 1'b1;
                     fd_o_q    <= 8'hA5;
`else
                     state_q <= S_IDLE;
`endif
                  end else if (got) begin
                     fx_wr_q <= 1'b1;
                     waddr_q <= addr_q;
                     wdata_q <= usb_fd_i;
                     addr_q  <= addr_nx;
                     cnt_q   <= cnt_q - 9'd1;
                  end
               end
               S_RREQ: state_q <= S_RCAP;
               S_RCAP: begin
                  fd_o_q    <= fx_q;
                  fifoadr_q <= 2'b10;
                  fd_oe_q   <= 1'b1;
                  state_q   <= S_RPUSH;
               end
               S_RPUSH: if (put) begin
                  addr_q <= addr_nx;
                  cnt_q  <= cnt_q - 9'd1;
                  if (cnt_q == 9'd1) begin
                     state_q    <= S_PKTEND;
                     pktend_n_q <= 1'b0;
                     fd_oe_q    <= 1'b0;
                  end else begin
                     state_q <= S_RREQ;
                     fx_rd_q <= 1'b1;
                     raddr_q <= addr_nx;
                  end
               end
`ifdef FX2_BRIDGE_ACK_EN
               S_ACK: if (put) begin
                  state_q    <= S_PKTEND;
                  pktend_n_q <= 1'b0;
                  fd_oe_q    <= 1'b0;
               end
`endif
               S_PKTEND: state_q <= S_IDLE;
               default:  state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign usb_fd_o     = fd_o_q;
   assign usb_fd_oe    = fd_oe_q;
   assign usb_fifoadr  = fifoadr_q;
   assign usb_sloe_n   = sloe_n_q;
   assign usb_slrd_n   = slrd_n_q;
   assign usb_slwr_n   = slwr_n_q;
   assign usb_pktend_n = pktend_n_q;
   assign fx_waddr     = waddr_q;
   assign fx_wr        = fx_wr_q;
   assign fx_data      = wdata_q;
   assign fx_raddr     = raddr_q;
   assign fx_rd        = fx_rd_q;

endmodule
